// File: rtl/seq_gates_pkg.sv
// Shared types for the gate-network stimulus driver: FSM states, the
// 3-bit stimulus vector, and the reference function of the gate network.
package seq_gates_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Packed so that bit0 drives in0, bit1 drives in1 and bit2 drives in2.
  typedef struct packed {
    logic in2;
    logic in1;
    logic in0;
  } vec_t;

  // Value the registered gate network should return for a vector.
  function automatic logic expected_of(vec_t v);
    return ~(v.in0 ^ v.in1) & v.in2;
  endfunction

endpackage

// File: rtl/seq_gates_drv_if.sv
// Vector input stream and response output stream of the stimulus driver.
// The master is the stimulus source / response sink; the slave is the driver.
interface seq_gates_drv_if;

  logic                 vec_val;
  logic                 vec_rdy;
  seq_gates_pkg::vec_t  vec;
  logic                 resp_val;
  logic                 resp_bit;

  modport master (
    output vec_val, vec,
    input  vec_rdy, resp_val, resp_bit
  );

  modport slave (
    input  vec_val, vec,
    output vec_rdy, resp_val, resp_bit
  );

endinterface

// File: rtl/seq_gates_drv_fifo.sv
// Synchronous FIFO of DEPTH entries (power of two) with full/empty flags and
// an occupancy count. Pushes while full and pops while empty are ignored.
module seq_gates_drv_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage write.
  // NOTE: the data array is deliberately not reset; the pointers and count
  // alone define which entries are valid, and a reset array costs flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/seq_gates_drv.sv
// Stimulus driver for the registered gate network out = ~(in0 ^ in1) & in2.
// Buffers vectors, drives them from flops, and captures gate_out two cycles
// after issue as a response stream. Define SEQ_GATES_DRV_CHECK_EN to enable
// the response checker (sticky err flag and saturating mismatch_cnt).
module seq_gates_drv
  import seq_gates_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_gates_drv_if.slave     bus,
  input  logic               hold,
  output logic               in0,
  output logic               in1,
  output logic               in2,
  input  logic               gate_out,
  output logic               idle,
  output logic               err,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  vec_t                   head;
  logic                   push;
  logic                   pop;
  logic                   s0_val;
  logic                   s1_val;
  logic                   pipe_busy;
  logic                   fifo_busy;
  state_t                 state;
  state_t                 state_nxt;

  assign push        = bus.vec_val & ~fifo_full;
  assign pop         = ~fifo_empty & ~hold;
  assign bus.vec_rdy = ~fifo_full;
  assign pipe_busy   = s0_val | s1_val;
  assign fifo_busy   = (fifo_count != '0);

  seq_gates_drv_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.vec),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue: drive the popped head onto the network and track it in the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {in2, in1, in0} <= 3'b000;
      s0_val          <= 1'b0;
      s1_val          <= 1'b0;
    end else begin
      {in2, in1, in0} <= pop ? head : 3'b000;
      s0_val          <= pop;
      s1_val          <= s0_val;
    end
  end

  // Capture: gate_out is valid for the stage-1 vector at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_val <= 1'b0;
      bus.resp_bit <= 1'b0;
    end else begin
      bus.resp_val <= s1_val;
      if (s1_val) bus.resp_bit <= gate_out;
    end
  end

`ifdef SEQ_GATES_DRV_CHECK_EN
  logic s0_exp;
  logic s1_exp;
  logic mismatch;

  assign mismatch = s1_val & (gate_out != s1_exp);

  // Expected-value field travelling alongside the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_exp <= 1'b0;
      s1_exp <= 1'b0;
    end else begin
      s0_exp <= pop ? expected_of(head) : 1'b0;
      s1_exp <= s0_exp;
    end
  end

  // Checker: clear wins over a same-edge mismatch; count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err          <= 1'b0;
      mismatch_cnt <= '0;
    end else if (err_clr) begin
      err          <= 1'b0;
      mismatch_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
  assign mismatch_cnt   = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a same-edge push keeps the FSM out of IDLE.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (push) state_nxt = RUN;
      RUN:   if (!pop) state_nxt = (pipe_busy || fifo_busy || push) ? DRAIN : IDLE;
      DRAIN: begin
        if (pop)                          state_nxt = RUN;
        else if (!pipe_busy && !fifo_busy) state_nxt = push ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    idle = (state == IDLE);
  end

endmodule
